// File: rtl/instr_encoder.sv
// RV32I field-tuple to instruction-word encoder with a write FIFO streaming into imem.
// Optional macro ENC_RANGE_CHECK_EN rejects tuples whose immediate cannot be encoded.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        addr_load,
  input  logic [31:0] addr_value,
  output logic        err,
  input  logic        err_clr,
  output logic        idle
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0] f7;
  logic [2:0] f3;
  logic [6:0] op;
  assign f7 = opcode[16:10];
  assign f3 = opcode[9:7];
  assign op = opcode[6:0];

  logic [31:0]   fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          in_ready_q, in_ready_d;
  logic          err_q, err_d;
  logic          idle_q, idle_d;

  logic [31:0] enc_word_c;
  logic        legal_c;
  logic        range_ok_c;
  logic        accept_c;
  logic        push_c;
  logic        pop_c;
  logic [31:0] head_c;

  // Only the word-aligned part of a loaded address is meaningful.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^addr_value[1:0];

  // Encoder: format chosen by opcode7; fields outside the encodable bits are truncated.
  always_comb begin
    enc_word_c = '0;
    legal_c    = 1'b1;
    range_ok_c = 1'b1;
    case (op)
      OP_R: enc_word_c = {f7, rs2, rs1, f3, rd, op};
      OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          enc_word_c = {f7, imm[4:0], rs1, f3, rd, op};
`ifdef ENC_RANGE_CHECK_EN
          range_ok_c = (imm[31:5] == '0);
`endif
        end else begin
          enc_word_c = {imm[11:0], rs1, f3, rd, op};
`ifdef ENC_RANGE_CHECK_EN
          range_ok_c = (imm[31:11] == {21{imm[11]}});
`endif
        end
      end
      OP_LOAD, OP_JALR: begin
        enc_word_c = {imm[11:0], rs1, f3, rd, op};
`ifdef ENC_RANGE_CHECK_EN
        range_ok_c = (imm[31:11] == {21{imm[11]}});
`endif
      end
      OP_STORE: begin
        enc_word_c = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
`ifdef ENC_RANGE_CHECK_EN
        range_ok_c = (imm[31:11] == {21{imm[11]}});
`endif
      end
      OP_BRANCH: begin
        enc_word_c = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
`ifdef ENC_RANGE_CHECK_EN
        range_ok_c = (imm[31:12] == {20{imm[12]}}) && !imm[0];
`endif
      end
      OP_LUI, OP_AUIPC: begin
        enc_word_c = {imm[31:12], rd, op};
`ifdef ENC_RANGE_CHECK_EN
        range_ok_c = (imm[11:0] == '0);
`endif
      end
      OP_JAL: begin
        enc_word_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
`ifdef ENC_RANGE_CHECK_EN
        range_ok_c = (imm[31:20] == {12{imm[20]}}) && !imm[0];
`endif
      end
      default: legal_c = 1'b0;
    endcase
  end

  // Handshake, FIFO bookkeeping and next values of all registered outputs.
  always_comb begin
    accept_c   = in_valid & in_ready_q;
    push_c     = accept_c & legal_c & range_ok_c;
    pop_c      = we_q & mem_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    err_d      = err_q;
    head_c     = '0;

    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // addr_load overrides the post-write increment.
    if (addr_load)  addr_d = {addr_value[31:2], 2'b00};
    else if (pop_c) addr_d = addr_q + 32'd4;

    // Setting wins over a same-edge clear.
    if (accept_c && !(legal_c && range_ok_c)) err_d = 1'b1;
    else if (err_clr)                         err_d = 1'b0;

    // The slot being written this edge may already be the next head.
    if (push_c && (wr_ptr_q == rd_ptr_d)) head_c = enc_word_c;
    else                                  head_c = fifo_q[rd_ptr_d];

    we_d       = (count_d != '0);
    wdata_d    = we_d ? head_c : '0;
    in_ready_d = (count_d != CW'(DEPTH));
    idle_d     = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= enc_word_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
      idle_q     <= idle_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, backpressure, push/pop overlap,
// address load, error flag and reset-mid-write.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        addr_load;
  logic [31:0] addr_value;
  logic        err;
  logic        err_clr;
  logic        idle;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .addr_load(addr_load), .addr_value(addr_value),
    .err(err), .err_clr(err_clr), .idle(idle)
  );

  typedef struct {
    string       name;
    logic [16:0] op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [16:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    opcode = o; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1'b1;
  endtask

  // Add x<d>,x0,x0 : a distinct word per destination register.
  function automatic logic [31:0] add_word(input logic [4:0] d);
    return {7'd0, 5'd0, 5'd0, 3'd0, d, 7'h33};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"add",  17'h00033, 5'd3, 5'd1, 5'd2, 32'h0,        32'h002081B3};
    vecs[1] = '{"addi", 17'h00013, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093};
    vecs[2] = '{"srai", 17'h08293, 5'd5, 5'd6, 5'd0, 32'd3,        32'h40335293};
    vecs[3] = '{"sw",   17'h00123, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423};
    vecs[4] = '{"beq",  17'h00063, 5'd0, 5'd1, 5'd2, 32'd16,       32'h00208863};
    vecs[5] = '{"jal",  17'h0006F, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h001000EF};

    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    mem_ready = 1'b1; addr_load = 1'b0; addr_value = '0; err_clr = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Encoding table, back to back with mem_ready=1.
    exp_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      step();
      chk({vecs[i].name, "_we"}, 32'(mem_we), 32'd1);
      chk({vecs[i].name, "_word"}, mem_wdata, vecs[i].word);
      chk({vecs[i].name, "_addr"}, mem_addr, exp_addr);
      exp_addr += 32'd4;
    end
    in_valid = 1'b0;
    step();
    chk("table_drain_we", 32'(mem_we), 32'd0);
    chk("table_drain_idle", 32'(idle), 32'd1);
    chk("table_end_addr", mem_addr, 32'h18);

    // Backpressure: fill the FIFO while imem stalls.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(17'h00033, 5'(10 + i), 5'd0, 5'd0, 32'h0);
      step();
      chk("bp_head_word", mem_wdata, add_word(5'd10));
      chk("bp_head_addr", mem_addr, exp_addr);
    end
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_idle", 32'(idle), 32'd0);
    drive(17'h00033, 5'd20, 5'd0, 5'd0, 32'h0);
    step();
    chk("bp_no_accept_word", mem_wdata, add_word(5'd10));
    chk("bp_still_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rel_we", 32'(mem_we), 32'd1);
      chk("bp_rel_word", mem_wdata, add_word(5'(10 + i)));
      chk("bp_rel_addr", mem_addr, exp_addr);
      exp_addr += 32'd4;
      step();
    end
    chk("bp_idle", 32'(idle), 32'd1);
    chk("bp_we_off", 32'(mem_we), 32'd0);

    // Push and pop in the same edge at count=2.
    mem_ready = 1'b0;
    drive(17'h00033, 5'd1, 5'd0, 5'd0, 32'h0); step();
    drive(17'h00033, 5'd2, 5'd0, 5'd0, 32'h0); step();
    mem_ready = 1'b1;
    drive(17'h00033, 5'd3, 5'd0, 5'd0, 32'h0); step();
    chk("pp_word_b", mem_wdata, add_word(5'd2));
    chk("pp_ready", 32'(in_ready), 32'd1);
    drive(17'h00033, 5'd4, 5'd0, 5'd0, 32'h0); step();
    chk("pp_word_c", mem_wdata, add_word(5'd3));
    in_valid = 1'b0;
    step();
    chk("pp_word_d", mem_wdata, add_word(5'd4));
    chk("pp_addr_d", mem_addr, exp_addr + 32'd12);
    step();
    chk("pp_idle", 32'(idle), 32'd1);
    exp_addr += 32'd16;

    // addr_load in the same edge as a completing write.
    mem_ready = 1'b0;
    drive(17'h00033, 5'd7, 5'd0, 5'd0, 32'h0); step();
    drive(17'h00033, 5'd8, 5'd0, 5'd0, 32'h0); step();
    in_valid = 1'b0;
    chk("al_old_addr", mem_addr, exp_addr);
    chk("al_old_word", mem_wdata, add_word(5'd7));
    mem_ready = 1'b1; addr_load = 1'b1; addr_value = 32'h103;
    step();
    addr_load = 1'b0;
    chk("al_new_addr", mem_addr, 32'h100);
    chk("al_new_word", mem_wdata, add_word(5'd8));
    step();
    chk("al_after_addr", mem_addr, 32'h104);
    chk("al_idle", 32'(idle), 32'd1);

    // Illegal opcode, then clear colliding with another illegal tuple.
    chk("ill_ready_pre", 32'(in_ready), 32'd1);
    drive(17'h0007F, 5'd1, 5'd0, 5'd0, 32'h0); step();
    in_valid = 1'b0;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_no_we", 32'(mem_we), 32'd0);
    chk("ill_idle", 32'(idle), 32'd1);
    drive(17'h0007F, 5'd2, 5'd0, 5'd0, 32'h0); err_clr = 1'b1; step();
    in_valid = 1'b0;
    chk("ill_set_wins", 32'(err), 32'd1);
    step();
    err_clr = 1'b0;
    chk("ill_cleared", 32'(err), 32'd0);

    // ADDI with imm=0x800: rejected under range checking, truncated otherwise.
    drive(17'h00013, 5'd1, 5'd0, 5'd0, 32'h800); step();
    in_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    chk("rng_err", 32'(err), 32'd1);
    chk("rng_no_we", 32'(mem_we), 32'd0);
`else
    chk("rng_err", 32'(err), 32'd0);
    chk("rng_we", 32'(mem_we), 32'd1);
    chk("rng_word", mem_wdata, 32'h80000093);
    chk("rng_addr", mem_addr, 32'h104);
`endif
    step();

    // Reset while words are queued.
    mem_ready = 1'b0;
    drive(17'h00033, 5'd9, 5'd0, 5'd0, 32'h0); step();
    drive(17'h00033, 5'd9, 5'd0, 5'd0, 32'h0); step();
    in_valid = 1'b0;
    chk("mid_we_pre", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step();
    chk("mid_after_we", 32'(mem_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder: accepts decoded RV32I fields (packed opcode, rd, rs1, rs2, imm) over a valid/ready handshake and re-encodes them into 32-bit instruction words.
- Encoded words are buffered in a small FIFO, then streamed as sequential word writes into instruction memory.
- Used by the debug/loader path to build programs in imem without a host-side assembler.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- BASE_ADDR, 32'h0000_0000, reset value of the write address (word aligned).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder can accept
- opcode  in  17  {funct7[16:10], funct3[9:7], opcode7[6:0]}, same packing as the decoder output
- rd  in  5  destination register
- rs1  in  5  source 1
- rs2  in  5  source 2
- imm  in  32  immediate, unshifted byte-offset value
- mem_we  out  1  write request to imem
- mem_ready  in  1  imem accepts the write
- mem_addr  out  32  byte address of the write
- mem_wdata  out  32  encoded instruction
- addr_load  in  1  load the write address
- addr_value  in  32  new address; bits [1:0] ignored
- err  out  1  sticky error
- err_clr  in  1  clear err
- idle  out  1  FIFO empty and no write pending

Behaviour:
- Reset (async, rst_n=0) sets:
  - FIFO empty
  - in_ready=0 while in reset, 1 after
  - mem_we=0, mem_wdata=0
  - mem_addr=BASE_ADDR
  - err=0, idle=1
- Accept: an edge with in_valid&in_ready. Encoding is combinational on the input fields; the word is pushed into the FIFO at the accepting edge.
- in_ready = !full. No pass-through when full.
- Encoding selected by opcode[6:0]:
  - R, 0110011: {f7, rs2, rs1, f3, rd, op}.
  - I, 0010011 / 0000011 / 1100111: {imm[11:0], rs1, f3, rd, op}.
  - I shifts (op 0010011 with f3=001/101): {f7, imm[4:0], rs1, f3, rd, op}.
  - S, 0100011: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B, 1100011: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U, 0110111 / 0010111: {imm[31:12], rd, op}.
  - J, 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Any other opcode7: tuple is still accepted (handshake completes), nothing is pushed, err is set.
- Write side:
  - When the FIFO is non-empty, mem_we=1 with mem_wdata = FIFO head and mem_addr = current address.
  - Latency: a word accepted at edge N drives mem_we in cycle N+1.
  - mem_we, mem_addr and mem_wdata are held stable until mem_ready=1.
  - On an edge with mem_we&mem_ready: pop the FIFO and add 4 to the address. The address wraps modulo 2^32.
- Simultaneous push and pop (FIFO not full): both occur and the count is unchanged.
- Pop from an empty FIFO is impossible, because mem_we=0 when empty.
- addr_load:
  - At an edge, mem_addr ← {addr_value[31:2], 2'b00}. This has priority over the +4 increment.
  - A write completing at the same edge used the old address.
  - The FIFO is not flushed.
- err:
  - Set by an illegal opcode or a range failure (see Optional Feature).
  - Cleared by err_clr; set wins if both occur at the same edge.
  - Does not block the handshake.
- idle = FIFO empty. It is registered-equivalent, derived from the count register.
- Reset mid-write: queued words are discarded and the address returns to BASE_ADDR.

Optional Feature:
- Macro: ENC_RANGE_CHECK_EN.
- When defined, the tuple is accepted but not pushed, and err is set, if the immediate is not encodable:
  - I/S: imm is not a sign-extension of imm[11:0].
  - Shift: imm[31:5] ≠ 0.
  - B: outside ±4 KiB or imm[0]=1.
  - J: outside ±1 MiB or imm[0]=1.
  - U: imm[11:0] ≠ 0.
- When undefined: out-of-range fields are silently truncated to the bits listed above, and err is raised only for illegal opcodes.

Test Plan:
- Encoding checks, each after reset with mem_ready=1:
  - ADD x3,x1,x2 (opcode 0x00033, rd=3, rs1=1, rs2=2) → mem_we one cycle later, mem_addr=0x0, mem_wdata=0x002081B3.
  - ADDI x1,x0,-1 (imm=0xFFFFFFFF) → 0xFFF00093.
  - SRAI x5,x6,3 (f7=0100000) → 0x40335293.
  - SW x2,8(x1) → 0x0020A423.
  - BEQ x1,x2,+16 → 0x00208863.
  - JAL x1,+2048 → 0x001000EF.
  - Addresses across the six writes: 0x0, 0x4, …, 0x14.
- Backpressure: hold mem_ready=0 and push 4 words → in_ready=0 after the 4th, mem_wdata/mem_addr stable. Release → 4 writes at consecutive addresses, then idle=1.
- Simultaneous push/pop at count=2 → count stays 2 and no word is lost or reordered.
- addr_load with addr_value=0x103 in the same edge as a completing write → that write lands at the old address, the next at 0x100.
- Illegal opcode7=0x7F → handshake completes, no mem_we, err=1. err_clr in the same edge as another illegal tuple → err stays 1.
- With ENC_RANGE_CHECK_EN, ADDI imm=0x800 → err=1 and no write. Without the macro → writes 0x80000093 (for rd=1, rs1=0) and err=0.
